ltssm_detect: RTL and testbench
===============================

Name: ltssm_detect

Overview:
- LTSSM Detect sub-state controller: sequences Detect.Quiet and Detect.Active for a WIDTH-lane link.
- Upstream of the receiver-detect analog model: drives rx_det_req and consumes rx_det_ack / rx_det_vld.
- Consumes per-lane electrical-idle-exit flags from the electrical-idle model.
- Reports the detected lane set and a go-to-Polling pulse to the top-level LTSSM.

Parameters:
- WIDTH, 4, number of lanes.
- QUIET_CYCLES, 12000, Detect.Quiet timeout in clk cycles (12 ms equivalent).
- RETRY_CYCLES, 12000, wait between the first and second Detect.Active passes.
- ACK_TIMEOUT, 2048, maximum cycles from req assertion to completion before abort.
- CNT_W, 16, width of the shared down-counter (must hold max of the above).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- det_en  in  1  level; high = LTSSM is in Detect; low forces IDLE.
- ei_exit  in  WIDTH  per-lane electrical-idle exit, level.
- rx_det_req  out  1  receiver-detect request, level.
- rx_det_ack  in  1  high while the analog detect is in progress; falling edge = result valid.
- rx_det_vld  in  WIDTH  per-lane receiver-present result; sampled on ack falling edge.
- det_lane_mask  out  WIDTH  lanes confirmed present; held until next pass.
- det_done  out  1  one-cycle pulse: exit to Polling.
- det_state  out  3  current state encoding (debug).
- det_fail_cnt  out  8  saturating count of passes that returned to Quiet.

Behaviour:
- Reset (rst=0, async) values: state IDLE, rx_det_req 0, det_lane_mask 0, det_done 0, det_fail_cnt 0, counter 0, first-pass mask 0.
- States: IDLE=0, QUIET=1, ACT_REQ=2, ACT_WAIT=3, ACT_EVAL=4, RETRY=5, DONE=6.
- IDLE: det_en=1 -> QUIET, counter loaded with QUIET_CYCLES-1.
- QUIET: counter decrements each cycle. Exit to ACT_REQ when counter==0 or |ei_exit. Both in the same cycle: go to ACT_REQ once.
- ACT_REQ:
  - rx_det_req=1.
  - On first cycle with rx_det_ack=1 -> ACT_WAIT; rx_det_req drops the following cycle (registered).
  - Counter loaded with ACK_TIMEOUT-1 on entry.
  - Timeout -> QUIET, pass counted as failure.
- ACT_WAIT:
  - Waits for rx_det_ack falling edge (registered previous ack=1, current=0).
  - Latches rx_det_vld into an internal result register in that cycle -> ACT_EVAL.
  - Same ACK_TIMEOUT abort applies.
- ACT_EVAL (one cycle), with R = result register:
  - R all-ones -> DONE, det_lane_mask=R.
  - R==0 -> QUIET, fail_cnt++.
  - R partial, first pass -> store R as first-pass mask, RETRY loaded with RETRY_CYCLES-1.
  - R partial, second pass, R == first-pass mask -> DONE, det_lane_mask=R.
  - R partial, second pass, mismatch -> QUIET, fail_cnt++.
- RETRY: counter to 0 -> ACT_REQ with second-pass flag set. The flag clears on entry to QUIET or DONE.
- DONE: det_done=1 for exactly one cycle -> IDLE. det_lane_mask holds until next ACT_EVAL write.
- det_en=0 in any state: next cycle -> IDLE, rx_det_req=0, pass flags cleared; det_lane_mask and det_fail_cnt kept.
- det_fail_cnt saturates at 255; no wrap.
- Counter arithmetic: unsigned CNT_W bits, decrement only when nonzero.
- rst low mid-handshake: req drops immediately (async). The analog side is allowed to complete; the stale ack is ignored because IDLE ignores ack.

Optional Feature:
- Macro: LTSSM_DETECT_FAST_SIM_EN.
- Defined: QUIET and RETRY timeouts use the fixed constant 64 cycles instead of QUIET_CYCLES / RETRY_CYCLES, for short regressions. All other behaviour is unchanged.
- Undefined: parameter values are used.

Decomposition:
- Shared package/include (alongside existing define header):
  - detect state encodings (DET_IDLE..DET_DONE);
  - FAST_SIM timeout constant 64;
  - fail-count width 8.
- One natural sub-module, ltssm_detect_timer: loadable, saturating-at-zero down-counter with a zero flag, reused for quiet, retry and ack timeouts.

Test Plan:
- No ei_exit, all lanes present (vld=4'b1111), QUIET_CYCLES=100:
  - req rises 101 cycles after det_en;
  - det_done pulses one cycle;
  - det_lane_mask=4'b1111.
- ei_exit[2] asserted at cycle 10 of QUIET: ACT_REQ entered next cycle, well before the timeout.
- vld=4'b0000: returns to QUIET, det_fail_cnt=1, second req after a further QUIET_CYCLES.
- Partial detect:
  - vld=4'b0011 then again 4'b0011 after RETRY_CYCLES -> det_done, mask=4'b0011;
  - vld=4'b0011 then 4'b0001 -> QUIET, fail_cnt incremented.
- Ack never asserted with ACK_TIMEOUT=50: req deasserts after 50 cycles, state QUIET, fail_cnt=1.
- Mid-sequence aborts:
  - det_en dropped during ACT_WAIT -> IDLE next cycle, req=0;
  - rst pulsed low during ACT_REQ -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ltssm_detect_pkg.sv
// Shared definitions for the LTSSM Detect controller: state encodings,
// the fast-simulation timeout constant and the failure-counter width.
// The fast timeout applies when LTSSM_DETECT_FAST_SIM_EN is defined.
package ltssm_detect_pkg;

  typedef enum logic [2:0] {
    DET_IDLE     = 3'd0,
    DET_QUIET    = 3'd1,
    DET_ACT_REQ  = 3'd2,
    DET_ACT_WAIT = 3'd3,
    DET_ACT_EVAL = 3'd4,
    DET_RETRY    = 3'd5,
    DET_DONE     = 3'd6
  } det_state_e;

  localparam int FAST_SIM_CYCLES = 64;
  localparam int FAIL_W          = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + FAIL_W'(1);
  endfunction

endpackage

// File: rtl/ltssm_detect_timer.sv
// Loadable down-counter that stops at zero and flags it. One instance is
// shared by the quiet, retry and acknowledge timeouts.
module ltssm_detect_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ltssm_detect.sv
// LTSSM Detect sub-state controller: Detect.Quiet / Detect.Active sequencing
// with a two-pass confirmation for partial lane sets. Defining
// LTSSM_DETECT_FAST_SIM_EN shortens the quiet and retry waits to a constant.
module ltssm_detect
  import ltssm_detect_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int QUIET_CYCLES = 12000,
  parameter int RETRY_CYCLES = 12000,
  parameter int ACK_TIMEOUT  = 2048,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              det_en,
  input  logic [WIDTH-1:0]  ei_exit,
  output logic              rx_det_req,
  input  logic              rx_det_ack,
  input  logic [WIDTH-1:0]  rx_det_vld,
  output logic [WIDTH-1:0]  det_lane_mask,
  output logic              det_done,
  output logic [2:0]        det_state,
  output logic [FAIL_W-1:0] det_fail_cnt
);

`ifdef LTSSM_DETECT_FAST_SIM_EN
  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(FAST_SIM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LOAD = CNT_W'(FAST_SIM_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LOAD = CNT_W'(RETRY_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

  det_state_e        state_q;
  logic              req_q, done_q, ack_q, second_q;
  logic [WIDTH-1:0]  mask_q, res_q, first_q;
  logic [FAIL_W-1:0] fail_q;

  logic              tmr_load, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic              ack_fall, eval_pass, eval_retry;

  assign ack_fall   = ack_q & ~rx_det_ack;
  // All lanes present, or a partial set confirmed identically on the second pass.
  assign eval_pass  = (&res_q) | (second_q & (res_q != '0) & (res_q == first_q));
  assign eval_retry = ~(&res_q) & (res_q != '0) & ~second_q;

  ltssm_detect_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  // Timer reload on every transition that starts a new timed wait.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = QUIET_LOAD;
    if (det_en) begin
      case (state_q)
        DET_IDLE:     tmr_load = 1'b1;
        DET_QUIET:    if (tmr_zero || |ei_exit) begin tmr_load = 1'b1; tmr_val = ACK_LOAD; end
        DET_ACT_REQ:  if (!rx_det_ack && tmr_zero) tmr_load = 1'b1;
        DET_ACT_WAIT: if (!ack_fall && tmr_zero) tmr_load = 1'b1;
        DET_ACT_EVAL: begin
          if (eval_retry) begin tmr_load = 1'b1; tmr_val = RETRY_LOAD; end
          else if (!eval_pass) tmr_load = 1'b1;
        end
        DET_RETRY:    if (tmr_zero) begin tmr_load = 1'b1; tmr_val = ACK_LOAD; end
        default:      ;
      endcase
    end
  end

  // Detect state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DET_IDLE;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      second_q <= 1'b0;
      mask_q   <= '0;
      res_q    <= '0;
      first_q  <= '0;
      fail_q   <= '0;
    end else begin
      ack_q  <= rx_det_ack;
      done_q <= 1'b0;
      if (!det_en) begin
        state_q  <= DET_IDLE;
        req_q    <= 1'b0;
        second_q <= 1'b0;
      end else begin
        case (state_q)
          DET_IDLE: state_q <= DET_QUIET;
          DET_QUIET: begin
            if (tmr_zero || |ei_exit) begin
              state_q <= DET_ACT_REQ;
              req_q   <= 1'b1;
            end
          end
          DET_ACT_REQ: begin
            if (rx_det_ack) begin
              state_q <= DET_ACT_WAIT;
              req_q   <= 1'b0;
            end else if (tmr_zero) begin
              state_q  <= DET_QUIET;
              req_q    <= 1'b0;
              second_q <= 1'b0;
              fail_q   <= sat_inc(fail_q);
            end
          end
          DET_ACT_WAIT: begin
            if (ack_fall) begin
              res_q   <= rx_det_vld;
              state_q <= DET_ACT_EVAL;
            end else if (tmr_zero) begin
              state_q  <= DET_QUIET;
              second_q <= 1'b0;
              fail_q   <= sat_inc(fail_q);
            end
          end
          DET_ACT_EVAL: begin
            if (eval_pass) begin
              state_q  <= DET_DONE;
              mask_q   <= res_q;
              done_q   <= 1'b1;
              second_q <= 1'b0;
            end else if (eval_retry) begin
              first_q <= res_q;
              state_q <= DET_RETRY;
            end else begin
              state_q  <= DET_QUIET;
              second_q <= 1'b0;
              fail_q   <= sat_inc(fail_q);
            end
          end
          DET_RETRY: begin
            if (tmr_zero) begin
              state_q  <= DET_ACT_REQ;
              req_q    <= 1'b1;
              second_q <= 1'b1;
            end
          end
          default: state_q <= DET_IDLE;
        endcase
      end
    end
  end

  assign rx_det_req    = req_q;
  assign det_done      = done_q;
  assign det_lane_mask = mask_q;
  assign det_state     = state_q;
  assign det_fail_cnt  = fail_q;

endmodule

// File: tb/tb_ltssm_detect.sv
// Bench for ltssm_detect: directed scenarios followed by randomized passes,
// checked against a pass-level reference model of the detect rules.
module tb_ltssm_detect;

  localparam int W  = 4;
  localparam int QC = 100;
  localparam int RC = 80;
  localparam int AT = 50;

  localparam int S_IDLE = 0, S_QUIET = 1, S_REQ = 2, S_WAIT = 3, S_RETRY = 5, S_DONE = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         det_en = 1'b0;
  logic [W-1:0] ei_exit = '0;
  logic         rx_det_req;
  logic         rx_det_ack = 1'b0;
  logic [W-1:0] rx_det_vld = '0;
  logic [W-1:0] det_lane_mask;
  logic         det_done;
  logic [2:0]   det_state;
  logic [7:0]   det_fail_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_mask   = '0;
  logic [W-1:0] m_first  = '0;
  logic         m_second = 1'b0;
  int           m_fail   = 0;

  ltssm_detect #(.WIDTH(W), .QUIET_CYCLES(QC), .RETRY_CYCLES(RC),
                 .ACK_TIMEOUT(AT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .det_en(det_en), .ei_exit(ei_exit),
    .rx_det_req(rx_det_req), .rx_det_ack(rx_det_ack), .rx_det_vld(rx_det_vld),
    .det_lane_mask(det_lane_mask), .det_done(det_done),
    .det_state(det_state), .det_fail_cnt(det_fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges until the request is seen (bounded).
  task automatic wait_req(output int n);
    n = 0;
    while (rx_det_req !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Answer one detect request with random latency, then check the outcome.
  task automatic pass_check(input logic [W-1:0] vld, input string tag, output int ph_o);
    int d, len, exp_st;
    d   = $urandom_range(0, 5);
    len = $urandom_range(1, 8);
    chk({tag, "_in_req"}, det_state, S_REQ);
    for (int i = 0; i < d; i++) begin rx_det_vld = W'($urandom); tick(); end
    rx_det_ack = 1'b1;
    tick();
    chk({tag, "_req_drop"}, rx_det_req, 1'b0);
    chk({tag, "_wait"}, det_state, S_WAIT);
    for (int i = 1; i < len; i++) begin rx_det_vld = W'($urandom); tick(); end
    rx_det_ack = 1'b0;
    rx_det_vld = vld;
    tick();
    rx_det_vld = W'($urandom);
    tick();
    // model
    if (vld == '1)                  exp_st = S_DONE;
    else if (vld == '0)             exp_st = S_QUIET;
    else if (!m_second)             exp_st = S_RETRY;
    else if (vld == m_first)        exp_st = S_DONE;
    else                            exp_st = S_QUIET;
    if (exp_st == S_DONE) begin m_mask = vld; m_second = 1'b0; end
    else if (exp_st == S_QUIET) begin m_fail = (m_fail == 255) ? 255 : m_fail + 1; m_second = 1'b0; end
    else begin m_first = vld; m_second = 1'b1; end
    chk({tag, "_state"}, det_state, exp_st);
    chk({tag, "_fail"}, det_fail_cnt, m_fail);
    chk({tag, "_mask"}, det_lane_mask, m_mask);
    chk({tag, "_done"}, det_done, exp_st == S_DONE);
    ph_o = exp_st;
    if (exp_st == S_DONE) begin
      tick();
      chk({tag, "_done_pulse"}, det_done, 1'b0);
      chk({tag, "_idle"}, det_state, S_IDLE);
      ph_o = S_IDLE;
    end
  endtask

  initial begin
    int n, ph, k;
    logic [W-1:0] v;

    // Reset values
    #2;
    chk("rst_state", det_state, S_IDLE);
    chk("rst_req", rx_det_req, 1'b0);
    chk("rst_mask", det_lane_mask, '0);
    chk("rst_done", det_done, 1'b0);
    chk("rst_fail", det_fail_cnt, 0);
    tick();
    rst = 1'b1;

    // All lanes present after full quiet
    det_en = 1'b1;
    wait_req(n);
    chk("a_req_latency", n, QC + 1);
    pass_check(4'b1111, "a", ph);

    // Electrical-idle exit cuts quiet short
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("b_no_req_yet", rx_det_req, 1'b0);
    ei_exit = 4'b0100;
    tick();
    ei_exit = '0;
    chk("b_ei_req", rx_det_req, 1'b1);
    pass_check(4'b0000, "b", ph);
    wait_req(n);
    chk("b_requiet", n, QC);

    // Partial set confirmed on second pass
    pass_check(4'b0011, "c1", ph);
    ei_exit = W'($urandom);
    wait_req(n);
    ei_exit = '0;
    chk("c_retry", n, RC);
    pass_check(4'b0011, "c2", ph);

    // Partial set mismatch on second pass
    wait_req(n);
    chk("d_req", n, QC + 1);
    pass_check(4'b0011, "d1", ph);
    wait_req(n);
    chk("d_retry", n, RC);
    pass_check(4'b0001, "d2", ph);

    // Acknowledge never arrives
    wait_req(n);
    chk("e_req", n, QC);
    n = 0;
    while (rx_det_req === 1'b1 && n < 200) begin tick(); n++; end
    m_fail = m_fail + 1;
    chk("e_timeout", n, AT);
    chk("e_state", det_state, S_QUIET);
    chk("e_fail", det_fail_cnt, m_fail);

    // det_en removed during ACT_WAIT
    wait_req(n);
    chk("f_req", n, QC);
    rx_det_ack = 1'b1;
    tick();
    chk("f_wait", det_state, S_WAIT);
    det_en = 1'b0;
    tick();
    chk("f_idle", det_state, S_IDLE);
    chk("f_req_low", rx_det_req, 1'b0);
    rx_det_ack = 1'b0;
    tick();
    chk("f_mask_kept", det_lane_mask, m_mask);
    chk("f_fail_kept", det_fail_cnt, m_fail);
    m_second = 1'b0;
    det_en = 1'b1;
    ph = S_IDLE;

    // Randomized passes
    for (int it = 0; it < 12; it++) begin
      if (ph == S_RETRY) begin
        ei_exit = W'($urandom);
        wait_req(n);
        ei_exit = '0;
        chk("r_retry", n, RC);
      end else if ($urandom_range(0, 1) == 1) begin
        if (ph == S_IDLE) tick();
        k = $urandom_range(0, 80);
        for (int i = 0; i < k; i++) tick();
        chk("r_no_early_req", rx_det_req, 1'b0);
        ei_exit = W'($urandom_range(1, 15));
        tick();
        ei_exit = '0;
        chk("r_ei_req", rx_det_req, 1'b1);
      end else begin
        wait_req(n);
        chk("r_quiet", n, (ph == S_IDLE) ? QC + 1 : QC);
      end
      case ($urandom_range(0, 3))
        0: v = 4'b1111;
        1: v = 4'b0000;
        default: v = (m_second && $urandom_range(0, 1) == 1) ? m_first : W'($urandom_range(1, 14));
      endcase
      pass_check(v, "r", ph);
    end

    // Reset during ACT_REQ takes effect immediately
    det_en = 1'b0;
    tick();
    det_en = 1'b1;
    m_second = 1'b0;
    wait_req(n);
    chk("g_req", n, QC + 1);
    rst = 1'b0;
    #1;
    chk("g_req_async", rx_det_req, 1'b0);
    chk("g_state", det_state, S_IDLE);
    chk("g_mask", det_lane_mask, '0);
    chk("g_fail", det_fail_cnt, 0);
    chk("g_done", det_done, 1'b0);
    rst = 1'b1;
    m_mask = '0; m_first = '0; m_fail = 0;

    // Failure counter saturation
    ei_exit = '1;
    for (int it = 0; it < 260; it++) begin
      wait_req(n);
      pass_check(4'b0000, "s", ph);
    end
    ei_exit = '0;
    chk("s_saturated", det_fail_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
